// File: rtl/logic_unit_sliced_seq_if.sv
// Handshake/operand bundle for the sliced logic unit.
// master drives requests, slave (the unit) returns status and result.
`default_nettype none

interface logic_unit_sliced_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output start, op, in1, in2,
    input  busy, done, result, zero
  );

  modport slave (
    input  start, op, in1, in2,
    output busy, done, result, zero
  );
endinterface

`default_nettype wire

// File: rtl/logic_unit_sliced_seq.sv
// Multi-cycle bitwise AND/OR/XOR/NOR unit, SLICE bits per cycle, LSB slice first,
// with start/busy/done handshake and a zero flag on the final result.
`default_nettype none

module logic_unit_sliced_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  logic_unit_sliced_seq_if.slave    bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NSLICE - 1);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_d;
  logic             busy_q;
  logic             done_q;
  logic             zero_q;

  function automatic logic [SLICE-1:0] slice_fn(input logic [1:0]       f,
                                                 input logic [SLICE-1:0] a,
                                                 input logic [SLICE-1:0] b);
    logic [SLICE-1:0] r;
    case (f)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Result with the current slice merged in; also feeds the zero flag on the last slice.
  always_comb begin
    result_d = result_q;
    result_d[cnt_q*SLICE +: SLICE] = slice_fn(op_q,
                                              a_q[cnt_q*SLICE +: SLICE],
                                              b_q[cnt_q*SLICE +: SLICE]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q      <= bus.in1;
            b_q      <= bus.in2;
            op_q     <= bus.op;
            result_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            state_q  <= IDLE;
          end
        end
        RUN: begin
          result_q <= result_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            zero_q  <= (result_d == '0);
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.zero   = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_sliced_seq.sv
// Directed bench for logic_unit_sliced_seq: 32/4 main instance plus 8/8 and 16/2 variants.
`default_nettype none

module tb_logic_unit_sliced_seq;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  logic_unit_sliced_seq_if #(.WIDTH(32)) bus32 ();
  logic_unit_sliced_seq_if #(.WIDTH(8))  bus8  ();
  logic_unit_sliced_seq_if #(.WIDTH(16)) bus16 ();

  logic_unit_sliced_seq #(.WIDTH(32), .SLICE(4)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
  logic_unit_sliced_seq #(.WIDTH(8),  .SLICE(8)) dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));
  logic_unit_sliced_seq #(.WIDTH(16), .SLICE(2)) dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  // Issues one op on the 32-bit unit; inputs are scrambled after accept to prove latching.
  task automatic do_op32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                         output logic [31:0] res, output logic zr, output int lat,
                         output int busy_cnt, output logic done_after);
    res = '0; zr = 1'b0; lat = 0; busy_cnt = 0;
    @(negedge clk);
    bus32.start = 1'b1; bus32.in1 = a; bus32.in2 = b; bus32.op = o;
    @(posedge clk);
    #1;
    bus32.start = 1'b0; bus32.in1 = ~a; bus32.in2 = ~b; bus32.op = ~o;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus32.busy === 1'b1) busy_cnt++;
      if (bus32.done === 1'b1) begin
        lat = n; res = bus32.result; zr = bus32.zero;
        break;
      end
    end
    @(negedge clk);
    done_after = bus32.done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus32.start = 1'b1; bus32.op = 2'b01; bus32.in1 = 32'hFFFF_FFFF; bus32.in2 = 32'h0;
    bus8.start = 1'b0;  bus8.op = 2'b00;  bus8.in1 = 8'h0;  bus8.in2 = 8'h0;
    bus16.start = 1'b0; bus16.op = 2'b00; bus16.in1 = 16'h0; bus16.in2 = 16'h0;
    repeat (3) @(negedge clk);
    total++; if (bus32.busy !== 1'b0) $display("FAIL reset_busy32: got %b want 0", bus32.busy); else passed++;
    total++; if (bus32.done !== 1'b0) $display("FAIL reset_done32: got %b want 0", bus32.done); else passed++;
    total++; if (bus32.result !== 32'h0) $display("FAIL reset_result32: got %h want 0", bus32.result); else passed++;
    total++; if (bus32.zero !== 1'b0) $display("FAIL reset_zero32: got %b want 0", bus32.zero); else passed++;
    total++; if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.result !== 8'h0 || bus8.zero !== 1'b0)
      $display("FAIL reset_dut8: got busy=%b done=%b result=%h zero=%b want all 0",
               bus8.busy, bus8.done, bus8.result, bus8.zero);
    else passed++;
    total++; if (bus16.busy !== 1'b0 || bus16.done !== 1'b0 || bus16.result !== 16'h0 || bus16.zero !== 1'b0)
      $display("FAIL reset_dut16: got busy=%b done=%b result=%h zero=%b want all 0",
               bus16.busy, bus16.done, bus16.result, bus16.zero);
    else passed++;
    reset = 1'b0;
    bus32.start = 1'b0;
    @(negedge clk);
    total++; if (bus32.busy !== 1'b0) $display("FAIL reset_idle_after: got busy %b want 0", bus32.busy); else passed++;
  endtask

  task automatic test_or();
    logic [31:0] res; logic zr, da; int lat, bc;
    do_op32(32'hF0F0_0000, 32'h0000_0F0F, 2'b01, res, zr, lat, bc, da);
    total++; if (res !== 32'hF0F0_0F0F) $display("FAIL or_result: got %h want f0f00f0f", res); else passed++;
    total++; if (zr !== 1'b0) $display("FAIL or_zero: got %b want 0", zr); else passed++;
    total++; if (lat !== 9) $display("FAIL or_latency: got %0d want 9", lat); else passed++;
    total++; if (bc !== 8) $display("FAIL or_busy_cycles: got %0d want 8", bc); else passed++;
    total++; if (da !== 1'b0) $display("FAIL or_done_width: got done %b want 0", da); else passed++;
    total++; if (bus32.result !== 32'hF0F0_0F0F) $display("FAIL or_result_held: got %h want f0f00f0f", bus32.result); else passed++;
  endtask

  task automatic test_logic_ops();
    logic [31:0] res; logic zr, da; int lat, bc;
    do_op32(32'hAAAA_AAAA, 32'h5555_5555, 2'b00, res, zr, lat, bc, da);
    total++; if (res !== 32'h0) $display("FAIL and_result: got %h want 0", res); else passed++;
    total++; if (zr !== 1'b1) $display("FAIL and_zero: got %b want 1", zr); else passed++;
    do_op32(32'hAAAA_AAAA, 32'h5555_5555, 2'b10, res, zr, lat, bc, da);
    total++; if (res !== 32'hFFFF_FFFF) $display("FAIL xor_result: got %h want ffffffff", res); else passed++;
    total++; if (zr !== 1'b0) $display("FAIL xor_zero: got %b want 0", zr); else passed++;
    do_op32(32'hAAAA_AAAA, 32'h5555_5555, 2'b11, res, zr, lat, bc, da);
    total++; if (res !== 32'h0) $display("FAIL nor_result: got %h want 0", res); else passed++;
    total++; if (zr !== 1'b1) $display("FAIL nor_zero: got %b want 1", zr); else passed++;
    do_op32(32'h1234_5678, 32'h0000_0000, 2'b11, res, zr, lat, bc, da);
    total++; if (res !== 32'hEDCB_A987) $display("FAIL nor_bitwise: got %h want edcba987", res); else passed++;
    total++; if (zr !== 1'b0) $display("FAIL nor_bitwise_zero: got %b want 0", zr); else passed++;
  endtask

  task automatic test_ignore();
    int busy_cnt, done_cnt; logic [31:0] res;
    busy_cnt = 0; done_cnt = 0; res = '0;
    @(negedge clk);
    bus32.start = 1'b1; bus32.in1 = 32'h1234_5678; bus32.in2 = 32'h0F0F_0F0F; bus32.op = 2'b00;
    @(posedge clk);
    #1 bus32.start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus32.busy === 1'b1) busy_cnt++;
      if (bus32.done === 1'b1) begin done_cnt++; res = bus32.result; end
      if (n == 3) begin bus32.start = 1'b1; bus32.in1 = 32'hFFFF_FFFF; bus32.op = 2'b01; end
      if (n == 4) bus32.start = 1'b0;
    end
    total++; if (res !== 32'h0204_0608) $display("FAIL ignore_result: got %h want 02040608", res); else passed++;
    total++; if (done_cnt !== 1) $display("FAIL ignore_done_count: got %0d want 1", done_cnt); else passed++;
    total++; if (busy_cnt !== 8) $display("FAIL ignore_busy_cycles: got %0d want 8", busy_cnt); else passed++;
  endtask

  task automatic test_back_to_back();
    int n1, n2, done_cnt; logic [31:0] r1, r2; logic z2, drop;
    n1 = 0; n2 = 0; done_cnt = 0; r1 = '0; r2 = '0; z2 = 1'b0; drop = 1'b0;
    @(negedge clk);
    bus32.start = 1'b1; bus32.in1 = 32'h0000_FFFF; bus32.in2 = 32'h0F0F_0F0F; bus32.op = 2'b10;
    @(posedge clk);
    #1;
    bus32.in1 = 32'h1111_1111; bus32.in2 = 32'h2222_2222; bus32.op = 2'b11;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (drop) begin bus32.start = 1'b0; drop = 1'b0; end
      if (bus32.done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) begin n1 = n; r1 = bus32.result; drop = 1'b1; end
        else if (done_cnt == 2) begin n2 = n; r2 = bus32.result; z2 = bus32.zero; end
      end
    end
    bus32.start = 1'b0;
    total++; if (r1 !== 32'h0F0F_F0F0) $display("FAIL b2b_result1: got %h want 0f0ff0f0", r1); else passed++;
    total++; if (r2 !== 32'hCCCC_CCCC) $display("FAIL b2b_result2: got %h want cccccccc", r2); else passed++;
    total++; if (z2 !== 1'b0) $display("FAIL b2b_zero2: got %b want 0", z2); else passed++;
    total++; if (n1 !== 9 || n2 - n1 !== 9) $display("FAIL b2b_spacing: got first=%0d gap=%0d want 9/9", n1, n2 - n1); else passed++;
    total++; if (done_cnt !== 2) $display("FAIL b2b_done_count: got %0d want 2", done_cnt); else passed++;
  endtask

  task automatic test_reset_abort();
    int done_cnt; logic [31:0] res; logic zr, da; int lat, bc;
    done_cnt = 0;
    @(negedge clk);
    bus32.start = 1'b1; bus32.in1 = 32'hFFFF_0000; bus32.in2 = 32'h00FF_00FF; bus32.op = 2'b01;
    @(posedge clk);
    #1 bus32.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (bus32.busy !== 1'b0 || bus32.done !== 1'b0) $display("FAIL abort_flags: got busy=%b done=%b want 0/0", bus32.busy, bus32.done); else passed++;
    total++; if (bus32.result !== 32'h0 || bus32.zero !== 1'b0) $display("FAIL abort_outputs: got result=%h zero=%b want 0/0", bus32.result, bus32.zero); else passed++;
    reset = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (bus32.done === 1'b1 || bus32.busy === 1'b1) done_cnt++;
    end
    total++; if (done_cnt !== 0) $display("FAIL abort_no_done: got %0d active cycles want 0", done_cnt); else passed++;
    do_op32(32'hFFFF_0000, 32'h00FF_00FF, 2'b01, res, zr, lat, bc, da);
    total++; if (res !== 32'hFFFF_00FF || lat !== 9) $display("FAIL abort_fresh_op: got %h lat %0d want ffff00ff lat 9", res, lat); else passed++;
  endtask

  task automatic test_params();
    int lat, bc; logic [7:0] r8; logic [15:0] r16; logic z8;
    lat = 0; r8 = '0; z8 = 1'b0;
    @(negedge clk);
    bus8.start = 1'b1; bus8.in1 = 8'h3C; bus8.in2 = 8'hC3; bus8.op = 2'b01;
    @(posedge clk);
    #1 bus8.start = 1'b0; bus8.in1 = 8'h00; bus8.in2 = 8'h00;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (bus8.busy === 1'b1 && bus8.done === 1'b1) lat = -1;
      if (bus8.done === 1'b1 && lat == 0) begin lat = n; r8 = bus8.result; z8 = bus8.zero; end
    end
    total++; if (r8 !== 8'hFF || z8 !== 1'b0) $display("FAIL p8_result: got %h zero %b want ff zero 0", r8, z8); else passed++;
    total++; if (lat !== 2) $display("FAIL p8_latency: got %0d want 2", lat); else passed++;
    lat = 0; bc = 0; r16 = '0;
    @(negedge clk);
    bus16.start = 1'b1; bus16.in1 = 16'hFFFF; bus16.in2 = 16'h8001; bus16.op = 2'b00;
    @(posedge clk);
    #1 bus16.start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus16.busy === 1'b1) bc++;
      if (bus16.done === 1'b1 && lat == 0) begin lat = n; r16 = bus16.result; end
    end
    total++; if (r16 !== 16'h8001) $display("FAIL p16_result: got %h want 8001", r16); else passed++;
    total++; if (lat !== 9 || bc !== 8) $display("FAIL p16_timing: got lat %0d busy %0d want 9/8", lat, bc); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    test_reset();
    test_or();
    test_logic_ops();
    test_ignore();
    test_back_to_back();
    test_reset_abort();
    test_params();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
